approx_add_scheduler: RTL and testbench
=======================================

Name: approx_add_scheduler

Overview:
- Round-robin scheduler that shares one external 16-bit approximate adder among NREQ requesters.
- Each request is a 32-bit add, executed as two sequenced 16-bit passes: low half, then high half with the low-half carry-out as carry-in.
- Sits between CNN accumulation lanes and a single shared segmented adder instance. The adder stays combinational and lives outside this block.

Parameters:
NREQ, 4, number of requesters (2..8)
ID_W, 2, width of the requester index; NREQ <= 2**ID_W required

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  NREQ  per-requester request valid
req_a  input  32*NREQ  operand A; requester i uses bits [32i+31:32i]
req_b  input  32*NREQ  operand B, same packing
req_ready  output  NREQ  one-hot accept strobe
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_y  output  32  sum {hi,lo}
rsp_cout  output  1  carry-out of high pass
rsp_id  output  ID_W  index of the requester served
busy  output  1  high in any state other than IDLE
adder_a  output  16  operand A to shared adder
adder_b  output  16  operand B to shared adder
adder_cin  output  1  carry-in to shared adder
adder_y  input  16  adder sum (combinational from adder_a/b/cin)
adder_cout  input  1  adder carry-out

Behaviour:
- Reset (async, immediate): state=IDLE; rr pointer = NREQ-1, so requester 0 wins first; all outputs 0; internal operand/sum/carry registers 0.
- FSM states: IDLE -> LO -> HI -> RSP -> IDLE.
- IDLE:
  - If any req_valid, pick g = first valid index scanning upward from pointer+1, wrapping modulo NREQ.
  - req_ready[g]=1 combinationally that cycle; at most one bit set. req_ready=0 in every other state.
  - On the edge: capture opA/opB = requester g operands, id=g, pointer=g; go to LO.
  - If no req_valid, stay in IDLE.
- LO:
  - adder_a=opA[15:0], adder_b=opB[15:0], adder_cin=0.
  - On the edge: sum_lo<=adder_y, c_lo<=adder_cout; go to HI.
- HI:
  - adder_a=opA[31:16], adder_b=opB[31:16], adder_cin=c_lo.
  - On the edge: sum_hi<=adder_y, cout<=adder_cout; go to RSP.
- RSP:
  - rsp_valid=1; rsp_y={sum_hi,sum_lo}, rsp_cout, rsp_id held stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready at the edge: go to IDLE.
- Adder ports in IDLE and RSP are driven 0. Adder ports come only from registers and state; there is no combinational path from req_* to adder_*.
- Latency: acceptance edge E; rsp_valid rises after edge E+2. A stall-free op occupies 4 cycles, so the earliest next accept is the cycle after the response handshake.
- Width rule: no saturation; the 33-bit result is {rsp_cout, rsp_y}. The carry from the low pass propagates only through adder_cin. Any approximation is the adder's.
- Requester rules:
  - Must hold req_valid and operands stable until its req_ready.
  - A valid is ignored while busy. Other requesters' valids never affect an op in flight.
- rsp_y, rsp_cout and rsp_id retain their last values outside RSP, but they are valid only with rsp_valid.
- Simultaneous events:
  - A requester granted with valid still high after acceptance is treated as a new request at the next IDLE. It gets no repeat priority: the pointer has moved past it.
  - If only the same requester is valid, it is served again.
- Reset mid-operation: the op is discarded, no response is produced, and the accepted request is lost.
- Out-of-range ids (NREQ < 2**ID_W) are never granted.

Test Plan:
- Bench adder model: exact, {cout,y}=a+b+cin.
- Reset: assert rst mid-cycle -> all outputs 0 immediately, busy=0; after release with req_valid=0 -> stays IDLE.
- Single op, req0 a=0x0001_FFFF b=0x0000_0001 -> req_ready=4'b0001 one cycle; LO adder_cin=0, HI adder_cin=1; rsp_valid after E+2 with rsp_y=0x0002_0000, rsp_cout=0, rsp_id=0.
- Overflow, req2 a=0xFFFF_FFFF b=0x0000_0001 -> rsp_y=0x0000_0000, rsp_cout=1, rsp_id=2.
- Round-robin: all four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0 with 4-cycle spacing; req_ready never multi-hot.
- Backpressure: hold rsp_ready=0 for 5 cycles in RSP -> rsp_* stable, req_ready=0, busy=1; the handshake then returns to IDLE, and the next grant goes to the next valid requester after the last grant.
- Async reset asserted in HI with req1 a=0x1234_5678 b=0x1111_1111 -> rsp_valid never rises, adder ports 0; a fresh request after reset returns 0x2345_6789.

Source files
------------

// File: rtl/approx_add_if.sv
// ============================================================================
// Module      : approx_add_if
// Description : Request, response and shared-adder bundle for approx_add_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface approx_add_if #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_y;
    logic                 rsp_cout;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          adder_a;
    logic [15:0]          adder_b;
    logic                 adder_cin;
    logic [15:0]          adder_y;
    logic                 adder_cout;

    // Requesters, response consumer and the external adder sit on this side.
    modport master (
        output req_valid, req_a, req_b, rsp_ready, adder_y, adder_cout,
        input  req_ready, rsp_valid, rsp_y, rsp_cout, rsp_id,
               adder_a, adder_b, adder_cin
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, adder_y, adder_cout,
        output req_ready, rsp_valid, rsp_y, rsp_cout, rsp_id,
               adder_a, adder_b, adder_cin
    );
endinterface

`default_nettype wire

// File: rtl/approx_add_scheduler.sv
// ============================================================================
// Module      : approx_add_scheduler
// Description : Round-robin sharing of one 16-bit adder for 32-bit two-pass adds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module approx_add_scheduler #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  wire          clk,
    input  wire          rst,
    approx_add_if.slave  bus,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [31:0]       op_a_q, op_a_d;
    logic [31:0]       op_b_q, op_b_d;
    logic [15:0]       sum_lo_q, sum_lo_d;
    logic [31:0]       rsp_y_q, rsp_y_d;
    logic              rsp_cout_q, rsp_cout_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;
    logic [15:0]       adder_a_q, adder_a_d;
    logic [15:0]       adder_b_q, adder_b_d;
    logic              adder_cin_q, adder_cin_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [NREQ-1:0]   req_ready_w;

    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int step);
        int sum_idx;
        sum_idx = (int'(base) + step) % NREQ;
        return sum_idx[ID_W-1:0];
    endfunction

    // Scan upward from the slot after the last winner; indices >= NREQ never appear.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_found && bus.req_valid[rr_index(ptr_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_index(ptr_q, k);
            end
        end
    end

    always_comb begin
        req_ready_w = '0;
        if (state_q == S_IDLE && grant_found && !rst) begin
            req_ready_w[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        sum_lo_d   = sum_lo_q;
        rsp_y_d    = rsp_y_q;
        rsp_cout_d = rsp_cout_q;
        rsp_id_d   = rsp_id_q;

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    op_a_d  = bus.req_a[32*int'(grant_idx) +: 32];
                    op_b_d  = bus.req_b[32*int'(grant_idx) +: 32];
                    id_d    = grant_idx;
                    ptr_d   = grant_idx;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                sum_lo_d = bus.adder_y;
                state_d  = S_HI;
            end
            S_HI: begin
                rsp_y_d    = {bus.adder_y, sum_lo_q};
                rsp_cout_d = bus.adder_cout;
                rsp_id_d   = id_q;
                state_d    = S_RSP;
            end
            S_RSP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rsp_valid_d = (state_d == S_RSP);
        busy_d      = (state_d != S_IDLE);

        // Adder drive is registered from the next state; the LO carry lands directly in adder_cin.
        adder_a_d   = '0;
        adder_b_d   = '0;
        adder_cin_d = 1'b0;
        case (state_d)
            S_LO: begin
                adder_a_d = op_a_d[15:0];
                adder_b_d = op_b_d[15:0];
            end
            S_HI: begin
                adder_a_d   = op_a_d[31:16];
                adder_b_d   = op_b_d[31:16];
                adder_cin_d = bus.adder_cout;
            end
            default: begin
                adder_a_d   = '0;
                adder_b_d   = '0;
                adder_cin_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= ID_W'(NREQ - 1);
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sum_lo_q    <= '0;
            rsp_y_q     <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            adder_a_q   <= '0;
            adder_b_q   <= '0;
            adder_cin_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sum_lo_q    <= sum_lo_d;
            rsp_y_q     <= rsp_y_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            adder_a_q   <= adder_a_d;
            adder_b_q   <= adder_b_d;
            adder_cin_q <= adder_cin_d;
        end
    end

    assign bus.req_ready = req_ready_w;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.adder_a   = adder_a_q;
    assign bus.adder_b   = adder_b_q;
    assign bus.adder_cin = adder_cin_q;
    assign busy          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_approx_add_scheduler.sv
// ============================================================================
// Module      : tb_approx_add_scheduler
// Description : Randomised and directed checks of approx_add_scheduler against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_approx_add_scheduler;
    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    approx_add_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

    approx_add_scheduler #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Exact stand-in for the shared adder.
    assign {bus.adder_cout, bus.adder_y} = {1'b0, bus.adder_a} + {1'b0, bus.adder_b} + {16'h0000, bus.adder_cin};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Transaction model: phase 0 idle, 1 low pass, 2 high pass, 3 response.
    int          m_phase;
    int          m_ptr;
    logic [31:0] m_a, m_b, m_y;
    logic        m_cout;
    logic [ID_W-1:0] m_rid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_ptr   <= NREQ - 1;
            m_a     <= '0;
            m_b     <= '0;
            m_y     <= '0;
            m_cout  <= 1'b0;
            m_rid   <= '0;
        end else begin
            case (m_phase)
                0: if (pick(bus.req_valid, m_ptr) >= 0) begin
                    m_ptr   <= pick(bus.req_valid, m_ptr);
                    m_a     <= bus.req_a[32*pick(bus.req_valid, m_ptr) +: 32];
                    m_b     <= bus.req_b[32*pick(bus.req_valid, m_ptr) +: 32];
                    m_phase <= 1;
                end
                1: m_phase <= 2;
                2: begin
                    {m_cout, m_y} <= {1'b0, m_a} + {1'b0, m_b};
                    m_rid         <= m_ptr[ID_W-1:0];
                    m_phase       <= 3;
                end
                default: if (bus.rsp_ready) m_phase <= 0;
            endcase
        end
    end

    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] rdy_smp = '0;
    logic [16:0]     exp_lo;
    logic [15:0]     exp_aa, exp_ab;
    logic            exp_cin;
    int              g_exp;

    initial forever begin
        @(negedge clk);
        g_exp   = pick(bus.req_valid, m_ptr);
        exp_rdy = '0;
        if (!rst && m_phase == 0 && g_exp >= 0) exp_rdy[g_exp] = 1'b1;
        exp_lo  = {1'b0, m_a[15:0]} + {1'b0, m_b[15:0]};
        exp_aa  = '0;
        exp_ab  = '0;
        exp_cin = 1'b0;
        if (m_phase == 1) begin
            exp_aa = m_a[15:0];
            exp_ab = m_b[15:0];
        end else if (m_phase == 2) begin
            exp_aa  = m_a[31:16];
            exp_ab  = m_b[31:16];
            exp_cin = exp_lo[16];
        end
        chk("req_ready", bus.req_ready, exp_rdy);
        chk("busy", busy, m_phase != 0);
        chk("rsp_valid", bus.rsp_valid, m_phase == 3);
        chk("adder_a", bus.adder_a, exp_aa);
        chk("adder_b", bus.adder_b, exp_ab);
        chk("adder_cin", bus.adder_cin, exp_cin);
        chk("rsp_y", bus.rsp_y, m_y);
        chk("rsp_cout", bus.rsp_cout, m_cout);
        chk("rsp_id", bus.rsp_id, m_rid);
        chk("onehot", $countones(bus.req_ready) <= 1, 1'b1);
        rdy_smp = bus.req_ready;
    end

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid[i]      = 1'b1;
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
    endtask

    task automatic wait_rsp(input string name);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        chk(name, bus.rsp_valid, 1'b1);
    endtask

    task automatic wait_grant(input string name);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.req_ready != '0) break;
        end
        chk(name, bus.req_ready != '0, 1'b1);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF;
            1:       return {$urandom_range(0, 65535), 16'hFFFF};
            default: return $urandom;
        endcase
    endfunction

    int          gid [5];
    int          gcyc[5];
    int          ng;
    logic [31:0] hold_y;
    logic [ID_W-1:0] hold_id;

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", busy, 1'b0);

        // Single op: low-half carry must ripple through adder_cin.
        @(posedge clk); #1;
        set_req(0, 32'h0001_FFFF, 32'h0000_0001);
        @(negedge clk) chk("t1_req_ready", bus.req_ready, 4'b0001);
        @(posedge clk); #1 bus.req_valid = '0;
        @(negedge clk);
        chk("t1_lo_cin", bus.adder_cin, 1'b0);
        chk("t1_lo_a", bus.adder_a, 16'hFFFF);
        @(negedge clk);
        chk("t1_hi_cin", bus.adder_cin, 1'b1);
        chk("t1_hi_a", bus.adder_a, 16'h0001);
        @(negedge clk);
        chk("t1_rsp_valid", bus.rsp_valid, 1'b1);
        chk("t1_rsp_y", bus.rsp_y, 32'h0002_0000);
        chk("t1_rsp_cout", bus.rsp_cout, 1'b0);
        chk("t1_rsp_id", bus.rsp_id, 2'd0);

        // Async reset mid-cycle during an op.
        @(posedge clk); #1;
        set_req(3, 32'h0000_00FF, 32'h0000_0001);
        @(posedge clk); #1 bus.req_valid = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_adder_a", bus.adder_a, 16'h0000);
        chk("rst_rsp_y", bus.rsp_y, 32'h0000_0000);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stays_idle", busy, 1'b0);

        // Overflow on requester 2.
        @(posedge clk); #1;
        set_req(2, 32'hFFFF_FFFF, 32'h0000_0001);
        @(negedge clk) chk("ovf_req_ready", bus.req_ready, 4'b0100);
        @(posedge clk); #1 bus.req_valid = '0;
        wait_rsp("ovf_rsp_timeout");
        chk("ovf_rsp_y", bus.rsp_y, 32'h0000_0000);
        chk("ovf_rsp_cout", bus.rsp_cout, 1'b1);
        chk("ovf_rsp_id", bus.rsp_id, 2'd2);

        // Round robin with all four valid.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom);
        ng = 0;
        for (int n = 0; n < 40 && ng < 5; n++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) gid[ng] = i;
                gcyc[ng] = cyc;
                ng++;
            end
        end
        chk("rr_grant_count", ng, 5);
        for (int k = 0; k < 5; k++) chk("rr_order", gid[k], k % NREQ);
        for (int k = 1; k < 5; k++) chk("rr_spacing", gcyc[k] - gcyc[k-1], 4);

        // Backpressure on the fifth op (requester 0).
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        wait_rsp("bp_rsp_timeout");
        hold_y  = bus.rsp_y;
        hold_id = bus.rsp_id;
        @(posedge clk); #1;
        set_req(0, $urandom, $urandom);
        set_req(2, $urandom, $urandom);
        repeat (5) begin
            @(negedge clk);
            chk("bp_y_stable", bus.rsp_y, hold_y);
            chk("bp_id_stable", bus.rsp_id, 2'd0);
            chk("bp_no_ready", bus.req_ready, 4'b0000);
            chk("bp_busy", busy, 1'b1);
        end
        chk("bp_id_held", hold_id, 2'd0);
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        wait_grant("bp_grant_timeout");
        chk("bp_next_grant", bus.req_ready, 4'b0100);
        @(posedge clk); #1 bus.req_valid = '0;
        wait_rsp("bp_drain_timeout");

        // Async reset while in the high pass discards the op.
        @(posedge clk); #1;
        set_req(1, 32'h1234_5678, 32'h1111_1111);
        wait_grant("hi_grant_timeout");
        @(posedge clk); #1 bus.req_valid = '0;
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("hi_rst_adder_a", bus.adder_a, 16'h0000);
        chk("hi_rst_adder_cin", bus.adder_cin, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("hi_rst_no_rsp", bus.rsp_valid, 1'b0);
        end
        @(posedge clk); #1;
        set_req(1, 32'h1234_5678, 32'h1111_1111);
        wait_grant("fresh_grant_timeout");
        chk("fresh_req_ready", bus.req_ready, 4'b0010);
        @(posedge clk); #1 bus.req_valid = '0;
        wait_rsp("fresh_rsp_timeout");
        chk("fresh_rsp_y", bus.rsp_y, 32'h2345_6789);
        chk("fresh_rsp_id", bus.rsp_id, 2'd1);

        // Randomised traffic; requesters hold operands until accepted.
        for (int n = 0; n < 500; n++) begin
            @(posedge clk); #1;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] || rdy_smp[i]) begin
                    bus.req_valid[i] = ($urandom_range(0, 2) == 0);
                    bus.req_a[32*i +: 32] = rnd32();
                    bus.req_b[32*i +: 32] = rnd32();
                end
            end
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("final_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
